// File: rtl/atconv_sched_if.sv
// Handshake and memory-port bundle between the atrous-conv sequencer and its datapath/memories.
// Latency: none, wires only.
// Backpressure: none; the done strobes from the datapath are the only flow control.
interface atconv_sched_if #(
  parameter int AW = 12,
  parameter int DW = 13
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic          tap_vld;
  logic [3:0]    tap_idx;
  logic          conv_done;
  logic [DW-1:0] conv_res;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          pool_vld;
  logic          pool_first;
  logic          pool_done;
  logic [DW-1:0] pool_res;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          csel;

  modport master (
    input  ready, conv_done, conv_res, pool_done, pool_res,
    output busy, iaddr, tap_vld, tap_idx, crd, caddr_rd, pool_vld, pool_first,
           cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output ready, conv_done, conv_res, pool_done, pool_res,
    input  busy, iaddr, tap_vld, tap_idx, crd, caddr_rd, pool_vld, pool_first,
           cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/atconv_sched.sv
// Sequencer for the atrous-conv engine: image tap addressing, layer-0 writes, 2x2 pool reads, layer-1 writes.
// Latency: 11 cycles per layer-0 pixel and 6 per layer-1 output with 1-cycle done response; outputs decode state.
// Backpressure: stalls indefinitely in the WAIT states until the datapath raises its done strobe.
module atconv_sched #(
  parameter int IMG_LOG2 = 6,
  parameter int DIL      = 2
) (
  input logic            clk,
  input logic            reset,
  atconv_sched_if.master bus
);
  localparam int AW   = 2 * IMG_LOG2;
  localparam int PL   = IMG_LOG2 - 1;
  localparam int SIDE = 1 << IMG_LOG2;

  typedef enum logic [2:0] {
    IDLE, CONV_TAP, CONV_WAIT, CONV_WR, POOL_RD, POOL_WAIT, POOL_WR, DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]       pix;   // layer-0 pixel, row in the upper half, column in the lower half
  logic [3:0]          tap;   // kernel tap 0..8, row-major
  logic [2*PL-1:0]     pidx;  // layer-1 output, i in the upper half, j in the lower half
  logic [1:0]          prd;   // pool read 0..3: bit1 selects row 2i+1, bit0 selects column 2j+1
  logic [IMG_LOG2-1:0] row, col, tap_row, tap_col;
  logic [PL-1:0]       pi, pj;

  // Offset a coordinate by step and replicate the border by clamping into the image.
  function automatic logic [IMG_LOG2-1:0] clamp_off(input logic [IMG_LOG2-1:0] p, input int step);
    int v;
    v = int'(p) + step;
    if (v < 0)
      clamp_off = '0;
    else if (v > SIDE - 1)
      clamp_off = '1;
    else
      clamp_off = v[IMG_LOG2-1:0];
  endfunction

  assign row     = pix[AW-1 -: IMG_LOG2];
  assign col     = pix[IMG_LOG2-1:0];
  assign pi      = pidx[2*PL-1 -: PL];
  assign pj      = pidx[PL-1:0];
  assign tap_row = clamp_off(row, (int'(tap) / 3 - 1) * DIL);
  assign tap_col = clamp_off(col, (int'(tap) % 3 - 1) * DIL);

  // State register; reset returns to IDLE from anywhere, so no strobe survives it
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Counters move only in their own states; each wraps to zero on the transition that leaves its phase
  always_ff @(posedge clk) begin
    if (reset) begin
      tap  <= '0;
      pix  <= '0;
      prd  <= '0;
      pidx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready) begin
            tap  <= '0;
            pix  <= '0;
            prd  <= '0;
            pidx <= '0;
          end
        end
        CONV_TAP: tap  <= (tap == 4'd8) ? 4'd0 : tap + 4'd1;
        CONV_WR:  pix  <= (&pix) ? '0 : pix + 1'b1;
        POOL_RD:  prd  <= (&prd) ? 2'd0 : prd + 2'd1;
        POOL_WR:  pidx <= (&pidx) ? '0 : pidx + 1'b1;
        default: ;
      endcase
    end
  end

  // Next state plus every output, decoded from state and counters; all outputs idle at zero
  always_comb begin
    state_nxt      = state;
    bus.busy       = 1'b0;
    bus.tap_vld    = 1'b0;
    bus.tap_idx    = '0;
    bus.iaddr      = '0;
    bus.crd        = 1'b0;
    bus.caddr_rd   = '0;
    bus.pool_vld   = 1'b0;
    bus.pool_first = 1'b0;
    bus.cwr        = 1'b0;
    bus.caddr_wr   = '0;
    bus.cdata_wr   = '0;
    bus.csel       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ready)
          state_nxt = CONV_TAP;
      end
      CONV_TAP: begin
        bus.busy    = 1'b1;
        bus.tap_vld = 1'b1;
        bus.tap_idx = tap;
        bus.iaddr   = {tap_row, tap_col};
        if (tap == 4'd8)
          state_nxt = CONV_WAIT;
      end
      CONV_WAIT: begin
        bus.busy = 1'b1;
        if (bus.conv_done)
          state_nxt = CONV_WR;
      end
      CONV_WR: begin
        bus.busy     = 1'b1;
        bus.cwr      = 1'b1;
        bus.caddr_wr = pix;
        bus.cdata_wr = bus.conv_res;
        state_nxt    = (&pix) ? POOL_RD : CONV_TAP;
      end
      POOL_RD: begin
        bus.busy       = 1'b1;
        bus.crd        = 1'b1;
        bus.pool_vld   = 1'b1;
        bus.pool_first = (prd == 2'd0);
        bus.caddr_rd   = {pi, prd[1], pj, prd[0]};
        if (&prd)
          state_nxt = POOL_WAIT;
      end
      POOL_WAIT: begin
        bus.busy = 1'b1;
        if (bus.pool_done)
          state_nxt = POOL_WR;
      end
      POOL_WR: begin
        bus.busy     = 1'b1;
        bus.cwr      = 1'b1;
        bus.csel     = 1'b1;
        bus.caddr_wr = {{(AW - 2 * PL){1'b0}}, pidx};
        bus.cdata_wr = bus.pool_res;
        state_nxt    = (&pidx) ? DONE : POOL_RD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_atconv_sched.sv
// Bench for atconv_sched: datapath model answers done strobes and pushes expected writes to a scoreboard.
// Latency: model answers each done one cycle after the last tap/read it observes.
// Backpressure: WAIT stalls exercised by withholding conv_done in the manual pixel test.
module tb_atconv_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atconv_sched_if bus ();
  atconv_sched dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        csel;
    logic [11:0] addr;
    logic [12:0] data;
  } wr_t;

  int  tests, fails, cyc;
  bit  auto_dp;
  int  conv_pix, pool_pix, tap_exp, rd_exp;
  bit  conv_pend, pool_pend;
  wr_t exp_q[$];
  bit  seen0[4096];
  bit  seen1[1024];
  int  n_wr0, n_wr1, dup_wr, both_strobe, busy_falls, busy_fall_cyc, last_wr0, last_wr1;
  logic busy_prev;
  logic [11:0] cap_tap63[9];
  logic [11:0] cap_pool0[4];
  logic [11:0] cap_pool31[4];
  logic [3:0]  first0;

  function automatic int clampi(int v);
    if (v < 0) return 0;
    if (v > 63) return 63;
    return v;
  endfunction

  function automatic logic [11:0] tap_addr(int pix, int t);
    int r, c;
    r = pix / 64 + 2 * (t / 3) - 2;
    c = pix % 64 + 2 * (t % 3) - 2;
    return 12'(clampi(r) * 64 + clampi(c));
  endfunction

  function automatic logic [11:0] pool_addr(int p, int k);
    return 12'((2 * (p / 32) + k / 2) * 64 + 2 * (p % 32) + k % 2);
  endfunction

  function automatic logic [12:0] conv_val(int p);
    return 13'((p * 37 + 291) & 8191);
  endfunction

  function automatic logic [12:0] pool_val(int p);
    return 13'(((p * 91) + 5) ^ 4660);
  endfunction

  function automatic logic [59:0] outs();
    return {bus.busy, bus.tap_vld, bus.crd, bus.cwr, bus.pool_vld, bus.pool_first, bus.csel,
            bus.iaddr, bus.caddr_rd, bus.caddr_wr, bus.tap_idx, bus.cdata_wr};
  endfunction

  task automatic model_clear();
    conv_pix = 0; pool_pix = 0; tap_exp = 0; rd_exp = 0;
    conv_pend = 0; pool_pend = 0; exp_q.delete();
    n_wr0 = 0; n_wr1 = 0; dup_wr = 0; both_strobe = 0;
    busy_falls = 0; busy_fall_cyc = 0; busy_prev = 1'b0; last_wr0 = -1; last_wr1 = -1;
    first0 = 4'h0;
    foreach (seen0[k]) seen0[k] = 1'b0;
    foreach (seen1[k]) seen1[k] = 1'b0;
  endtask

  // One clock: at the falling edge drive datapath responses, then observe and score the DUT.
  task automatic cycle();
    wr_t got, want;
    @(negedge clk);
    cyc++;
    if (!auto_dp) return;
    bus.conv_done = 1'b0;
    bus.pool_done = 1'b0;
    if (conv_pend) begin
      bus.conv_done = 1'b1;
      bus.conv_res  = conv_val(conv_pix);
      want.csel = 1'b0; want.addr = 12'(conv_pix); want.data = conv_val(conv_pix);
      exp_q.push_back(want);
      conv_pix++;
      conv_pend = 0;
    end
    if (pool_pend) begin
      bus.pool_done = 1'b1;
      bus.pool_res  = pool_val(pool_pix);
      want.csel = 1'b1; want.addr = 12'(pool_pix); want.data = pool_val(pool_pix);
      exp_q.push_back(want);
      pool_pix++;
      pool_pend = 0;
    end
    if (bus.cwr && bus.crd) both_strobe++;
    if (busy_prev && !bus.busy) begin
      busy_falls++;
      busy_fall_cyc = cyc;
    end
    busy_prev = bus.busy;
    if (bus.tap_vld) begin
      tests++;
      if (bus.tap_idx !== 4'(tap_exp) || bus.iaddr !== tap_addr(conv_pix, tap_exp)) begin
        fails++;
        $display("FAIL tap pix=%0d: got idx=%0d iaddr=%0d, want idx=%0d iaddr=%0d",
                 conv_pix, bus.tap_idx, bus.iaddr, tap_exp, tap_addr(conv_pix, tap_exp));
      end
      if (conv_pix == 4095) cap_tap63[tap_exp] = bus.iaddr;
      if (tap_exp == 8) begin tap_exp = 0; conv_pend = 1; end
      else tap_exp++;
    end
    if (bus.pool_vld) begin
      tests++;
      if (bus.caddr_rd !== pool_addr(pool_pix, rd_exp) || bus.pool_first !== (rd_exp == 0) ||
          bus.crd !== 1'b1 || bus.csel !== 1'b0) begin
        fails++;
        $display("FAIL pool_rd p=%0d k=%0d: got addr=%0d first=%0d crd=%0d csel=%0d, want addr=%0d first=%0d crd=1 csel=0",
                 pool_pix, rd_exp, bus.caddr_rd, bus.pool_first, bus.crd, bus.csel,
                 pool_addr(pool_pix, rd_exp), (rd_exp == 0));
      end
      if (pool_pix == 0) begin
        cap_pool0[rd_exp] = bus.caddr_rd;
        first0[3 - rd_exp] = bus.pool_first;
      end
      if (pool_pix == 1023) cap_pool31[rd_exp] = bus.caddr_rd;
      if (rd_exp == 3) begin rd_exp = 0; pool_pend = 1; end
      else rd_exp++;
    end
    if (bus.cwr) begin
      got.csel = bus.csel; got.addr = bus.caddr_wr; got.data = bus.cdata_wr;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got csel=%0d addr=%0d data=%0h, want no write", got.csel, got.addr, got.data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL wr_scoreboard: got csel=%0d addr=%0d data=%0h, want csel=%0d addr=%0d data=%0h",
                   got.csel, got.addr, got.data, want.csel, want.addr, want.data);
        end
      end
      if (!bus.csel) begin
        n_wr0++;
        last_wr0 = int'(bus.caddr_wr);
        if (seen0[bus.caddr_wr]) dup_wr++;
        seen0[bus.caddr_wr] = 1'b1;
      end else begin
        n_wr1++;
        last_wr1 = int'(bus.caddr_wr);
        if (bus.caddr_wr >= 12'd1024) dup_wr++;
        else begin
          if (seen1[bus.caddr_wr[9:0]]) dup_wr++;
          seen1[bus.caddr_wr[9:0]] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.ready = 1'b1;
    reset = 1'b1;
    repeat (2) cycle();
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL reset_outs: got %h, want 0", outs());
    end
    bus.ready = 1'b0;
    reset = 1'b0;
    repeat (2) cycle();
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL idle_no_ready: got %h, want 0", outs());
    end
  endtask

  task automatic test_pixel0_delay();
    logic [11:0] tbl[9] = '{12'd0, 12'd0, 12'd2, 12'd0, 12'd0, 12'd2, 12'd128, 12'd128, 12'd130};
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL busy_rise: got %0d, want 1", bus.busy);
    end
    for (int t = 0; t < 9; t++) begin
      if (t > 0) cycle();
      tests++;
      if ({bus.tap_vld, bus.tap_idx, bus.iaddr} !== {1'b1, 4'(t), tbl[t]}) begin
        fails++;
        $display("FAIL pix0_tap%0d: got vld=%0d idx=%0d iaddr=%0d, want vld=1 idx=%0d iaddr=%0d",
                 t, bus.tap_vld, bus.tap_idx, bus.iaddr, t, tbl[t]);
      end
      if (t == 3) begin bus.conv_done = 1'b1; bus.conv_res = 13'h0777; end
      if (t == 4) bus.conv_done = 1'b0;
    end
    for (int w = 0; w < 5; w++) begin
      cycle();
      tests++;
      if ({bus.busy, bus.tap_vld, bus.cwr, bus.crd, bus.pool_vld} !== 5'b10000) begin
        fails++;
        $display("FAIL wait_hold%0d: got busy/tap/cwr/crd/pool=%b, want 10000", w,
                 {bus.busy, bus.tap_vld, bus.cwr, bus.crd, bus.pool_vld});
      end
    end
    bus.conv_done = 1'b1;
    bus.conv_res  = 13'h0123;
    cycle();
    bus.conv_done = 1'b0;
    tests++;
    if ({bus.cwr, bus.crd, bus.csel, bus.caddr_wr, bus.cdata_wr} !== {1'b1, 1'b0, 1'b0, 12'd0, 13'h0123}) begin
      fails++;
      $display("FAIL pix0_write: got cwr=%0d crd=%0d csel=%0d addr=%0d data=%0h, want 1 0 0 0 123",
               bus.cwr, bus.crd, bus.csel, bus.caddr_wr, bus.cdata_wr);
    end
  endtask

  task automatic test_reset_mid_tap();
    repeat (4) cycle();
    tests++;
    if ({bus.tap_vld, bus.tap_idx} !== {1'b1, 4'd3}) begin
      fails++; $display("FAIL pix1_tap3: got vld=%0d idx=%0d, want 1 3", bus.tap_vld, bus.tap_idx);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL reset_mid_tap: got %h, want 0", outs());
    end
    repeat (3) cycle();
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL stay_idle_after_tap_reset: got %h, want 0", outs());
    end
  endtask

  task automatic test_full_run();
    logic [11:0] t63[9] = '{12'd3965, 12'd3967, 12'd3967, 12'd4093, 12'd4095, 12'd4095, 12'd4093, 12'd4095, 12'd4095};
    logic [11:0] tp0[4] = '{12'd0, 12'd1, 12'd64, 12'd65};
    logic [11:0] tp31[4] = '{12'd4030, 12'd4031, 12'd4094, 12'd4095};
    model_clear();
    auto_dp = 1'b1;
    cycle();
    cyc = 1;
    bus.ready = 1'b1;
    for (int k = 0; k < 60000 && busy_falls == 0; k++) begin
      cycle();
      if (cyc == 100) bus.ready = 1'b0;
    end
    bus.ready = 1'b0;
    repeat (3) cycle();
    auto_dp = 1'b0;
    tests++; if (busy_falls !== 1) begin fails++; $display("FAIL busy_falls: got %0d, want 1", busy_falls); end
    tests++; if (busy_fall_cyc !== 51202) begin fails++; $display("FAIL run_cycles: got %0d, want 51202", busy_fall_cyc); end
    tests++; if (n_wr0 !== 4096) begin fails++; $display("FAIL l0_writes: got %0d, want 4096", n_wr0); end
    tests++; if (n_wr1 !== 1024) begin fails++; $display("FAIL l1_writes: got %0d, want 1024", n_wr1); end
    tests++; if (dup_wr !== 0) begin fails++; $display("FAIL dup_addr: got %0d, want 0", dup_wr); end
    tests++; if (both_strobe !== 0) begin fails++; $display("FAIL cwr_crd_overlap: got %0d, want 0", both_strobe); end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d, want 0", exp_q.size()); end
    tests++; if (last_wr0 !== 4095) begin fails++; $display("FAIL last_l0_addr: got %0d, want 4095", last_wr0); end
    tests++; if (last_wr1 !== 1023) begin fails++; $display("FAIL last_l1_addr: got %0d, want 1023", last_wr1); end
    tests++; if (first0 !== 4'b1000) begin fails++; $display("FAIL pool0_first: got %b, want 1000", first0); end
    for (int t = 0; t < 9; t++) begin
      tests++;
      if (cap_tap63[t] !== t63[t]) begin
        fails++; $display("FAIL pix6363_tap%0d: got %0d, want %0d", t, cap_tap63[t], t63[t]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (cap_pool0[k] !== tp0[k] || cap_pool31[k] !== tp31[k]) begin
        fails++;
        $display("FAIL pool_corner_rd%0d: got %0d/%0d, want %0d/%0d", k, cap_pool0[k], cap_pool31[k], tp0[k], tp31[k]);
      end
    end
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL idle_after_done: got %h, want 0", outs());
    end
  endtask

  task automatic test_reset_mid_pool();
    bit hit;
    hit = 1'b0;
    model_clear();
    auto_dp = 1'b1;
    cycle();
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
    for (int k = 0; k < 50000 && !hit; k++) begin
      cycle();
      if (pool_pix == 3 && rd_exp == 2) hit = 1'b1;
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL pool_reach: got 0, want 1"); end
    reset = 1'b1;
    auto_dp = 1'b0;
    cycle();
    reset = 1'b0;
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL reset_mid_pool: got %h, want 0", outs());
    end
    repeat (2) cycle();
    tests++;
    if (outs() !== 60'd0) begin
      fails++; $display("FAIL stay_idle_after_pool_reset: got %h, want 0", outs());
    end
    model_clear();
    auto_dp = 1'b1;
    bus.ready = 1'b1;
    cycle();
    bus.ready = 1'b0;
    tests++;
    if ({bus.tap_vld, bus.tap_idx, bus.iaddr} !== {1'b1, 4'd0, 12'd0}) begin
      fails++;
      $display("FAIL restart_tap0: got vld=%0d idx=%0d iaddr=%0d, want 1 0 0", bus.tap_vld, bus.tap_idx, bus.iaddr);
    end
    repeat (36) cycle();
    auto_dp = 1'b0;
    tests++;
    if (n_wr0 !== 3 || last_wr0 !== 2 || n_wr1 !== 0) begin
      fails++;
      $display("FAIL restart_writes: got n0=%0d last=%0d n1=%0d, want 3 2 0", n_wr0, last_wr0, n_wr1);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; auto_dp = 1'b0;
    model_clear();
    reset = 1'b1;
    bus.ready = 1'b0; bus.conv_done = 1'b0; bus.conv_res = '0;
    bus.pool_done = 1'b0; bus.pool_res = '0;
    test_reset();
    test_pixel0_delay();
    test_reset_mid_tap();
    test_full_run();
    test_reset_mid_pool();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
